net_endpoint_adapter: RTL and testbench

//  Terminal-side adapter for the val/rdy test network: the client-facing end of the network ports.

---
 rtl/net_endpoint_pkg.sv | 80 ++++++++
 rtl/net_endpoint_tag_alloc.sv | 98 +++++++++
 rtl/net_endpoint_adapter.sv | 187 ++++++++++++++++++
 tb/tb_net_endpoint_adapter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_endpoint_pkg.sv
// ============================================================================
// Module      : net_endpoint_pkg
// Description : Shared types and helpers for the network endpoint adapter.
//               A net message is {dest, src, opaque, payload} with dest in
//               the MSBs. Field offsets and widths are functions of
//               (p, o, s) = (payload, opaque, src/dest widths).
//               Pack/unpack work on a fixed wide container (msg_wide_t);
//               callers cast to and from their real message width.
//               Widths must satisfy p+o+2s <= c_MSG_MAX_NBITS and
//               o <= c_TAG_MAX_NBITS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package net_endpoint_pkg;

  localparam int c_MSG_MAX_NBITS = 128;
  localparam int c_TAG_MAX_NBITS = 8;

  typedef logic [c_MSG_MAX_NBITS-1:0] msg_wide_t;
  typedef logic [c_TAG_MAX_NBITS-1:0] tag_wide_t;

  function automatic int payload_lsb();
    return 0;
  endfunction

  function automatic int opaque_lsb(input int p);
    return p;
  endfunction

  function automatic int src_lsb(input int p, input int o);
    return p + o;
  endfunction

  function automatic int dest_lsb(input int p, input int o, input int s);
    return p + o + s;
  endfunction

  function automatic int msg_nbits(input int p, input int o, input int s);
    return p + o + 2 * s;
  endfunction

  function automatic msg_wide_t field_mask(input int w);
    return (msg_wide_t'(1) << w) - msg_wide_t'(1);
  endfunction

  function automatic msg_wide_t msg_pack(
    input int        p,
    input int        o,
    input int        s,
    input msg_wide_t dest,
    input msg_wide_t src,
    input msg_wide_t opq,
    input msg_wide_t payload
  );
    return ((dest    & field_mask(s)) << dest_lsb(p, o, s))
         | ((src     & field_mask(s)) << src_lsb(p, o))
         | ((opq     & field_mask(o)) << opaque_lsb(p))
         | ((payload & field_mask(p)) << payload_lsb());
  endfunction

  function automatic msg_wide_t msg_field(
    input msg_wide_t msg,
    input int        lsb,
    input int        w
  );
    return (msg >> lsb) & field_mask(w);
  endfunction

  function automatic tag_wide_t msg_tag(
    input msg_wide_t msg,
    input int        p,
    input int        o
  );
    return tag_wide_t'(msg_field(msg, opaque_lsb(p), o));
  endfunction

endpackage

`default_nettype wire

// File: rtl/net_endpoint_tag_alloc.sv
// ============================================================================
// Module      : net_endpoint_tag_alloc
// Description : Opaque-tag allocator. Keeps a free vector over all 2**o tags,
//               hands out the lowest free tag in 0..MAX_OUTSTANDING-1 and
//               counts tags in flight. A tag freed in the same cycle as an
//               allocation is not visible to that allocation (the encoder
//               looks at the registered free vector only).
// Ports       : clk, rst (async, active-high)
//               i_alloc          - consume o_alloc_tag this cycle
//               o_alloc_ok       - a tag may be allocated
//               o_alloc_tag      - lowest free tag
//               i_free           - release i_free_tag this cycle
//               i_free_tag       - tag to release / query
//               o_free_tag_busy  - i_free_tag is currently outstanding
//               o_count          - tags in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_endpoint_tag_alloc
  import net_endpoint_pkg::*;
#(
  parameter int TAG_NBITS       = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc,
  output logic                 o_alloc_ok,
  output logic [TAG_NBITS-1:0] o_alloc_tag,
  input  logic                 i_free,
  input  logic [TAG_NBITS-1:0] i_free_tag,
  output logic                 o_free_tag_busy,
  output logic [TAG_NBITS:0]   o_count
);

  localparam int NUM_TAGS = 2 ** TAG_NBITS;

  typedef logic [TAG_NBITS-1:0] tag_t;
  typedef logic [TAG_NBITS:0]   cnt_t;

  localparam cnt_t c_MAX_CNT = cnt_t'(MAX_OUTSTANDING);

  logic [NUM_TAGS-1:0] r_free;
  cnt_t                r_count;

  logic                w_found;
  tag_t                w_low;
  logic [NUM_TAGS-1:0] w_free_nxt;
  cnt_t                w_count_nxt;

  // Lowest-index free tag; tags at or above MAX_OUTSTANDING are never
  // handed out, so they stay free and look non-outstanding on return.
  always_comb begin
    w_found = 1'b0;
    w_low   = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (r_free[i]) begin
        w_found = 1'b1;
        w_low   = tag_t'(i);
      end
    end
  end

  assign o_alloc_ok      = w_found & (r_count < c_MAX_CNT);
  assign o_alloc_tag     = w_low;
  assign o_free_tag_busy = ~r_free[i_free_tag];
  assign o_count         = r_count;

  always_comb begin
    w_free_nxt = r_free;
    if (i_alloc) begin
      w_free_nxt[o_alloc_tag] = 1'b0;
    end
    if (i_free) begin
      w_free_nxt[i_free_tag] = 1'b1;
    end
    w_count_nxt = r_count;
    case ({i_alloc, i_free})
      2'b10:   w_count_nxt = r_count + cnt_t'(1);
      2'b01:   w_count_nxt = r_count - cnt_t'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free  <= '1;
      r_count <= '0;
    end else begin
      r_free  <= w_free_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/net_endpoint_adapter.sv
// ============================================================================
// Module      : net_endpoint_adapter
// Description : Client-side endpoint of the val/rdy test network. Stamps
//               requests with {dest, src, opaque tag}, injects them through a
//               1-entry output register, and returns {src, payload} of
//               answered messages through a 1-entry response register.
//               Messages carrying a tag that is not in flight are dropped and
//               set the sticky err_tag flag.
//               Optional feature macro: NET_ENDPOINT_SRC_CHECK_EN - keeps a
//               per-tag destination table; a return whose src differs from
//               the recorded destination is dropped (tag stays in flight)
//               and sets err_tag.
// Ports       : clk, reset (async, active-high)
//               req_val/req_rdy/req_dest/req_payload         - client request
//               net_out_val/net_out_rdy/net_out_msg          - to network
//               net_in_val/net_in_rdy/net_in_msg             - from network
//               resp_val/resp_rdy/resp_src/resp_payload      - client response
//               err_tag     - sticky unknown-tag error
//               outstanding - tags in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_endpoint_adapter
  import net_endpoint_pkg::*;
#(
  parameter int p_payload_nbits   = 32,
  parameter int p_opaque_nbits    = 3,
  parameter int p_srcdest_nbits   = 3,
  parameter int p_src_id          = 0,
  parameter int p_max_outstanding = 4
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     req_val,
  output logic                                                     req_rdy,
  input  logic [p_srcdest_nbits-1:0]                               req_dest,
  input  logic [p_payload_nbits-1:0]                               req_payload,
  output logic                                                     net_out_val,
  input  logic                                                     net_out_rdy,
  output logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] net_out_msg,
  input  logic                                                     net_in_val,
  output logic                                                     net_in_rdy,
  input  logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] net_in_msg,
  output logic                                                     resp_val,
  input  logic                                                     resp_rdy,
  output logic [p_srcdest_nbits-1:0]                               resp_src,
  output logic [p_payload_nbits-1:0]                               resp_payload,
  output logic                                                     err_tag,
  output logic [p_opaque_nbits:0]                                  outstanding
);

  localparam int MSG_NBITS = msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);

  typedef logic [p_opaque_nbits-1:0]  tag_t;
  typedef logic [p_srcdest_nbits-1:0] sd_t;
  typedef logic [p_payload_nbits-1:0] pl_t;
  typedef logic [MSG_NBITS-1:0]       msg_t;

  localparam sd_t c_SRC_ID = sd_t'(p_src_id);

  logic      r_out_val;
  msg_t      r_out_msg;
  logic      r_resp_val;
  sd_t       r_resp_src;
  pl_t       r_resp_payload;
  logic      r_err_tag;

  logic      w_alloc_ok;
  tag_t      w_alloc_tag;
  logic      w_tag_busy;
  logic      w_req_fire;
  logic      w_in_fire;
  logic      w_src_ok;
  logic      w_accept;
  logic      w_reject;
  msg_wide_t w_in_wide;
  msg_wide_t w_out_wide;
  tag_t      w_in_tag;
  sd_t       w_in_src;
  pl_t       w_in_payload;

  // Message unpack / pack
  assign w_in_wide    = msg_wide_t'(net_in_msg);
  assign w_in_tag     = tag_t'(msg_tag(w_in_wide, p_payload_nbits, p_opaque_nbits));
  assign w_in_src     = sd_t'(msg_field(w_in_wide, src_lsb(p_payload_nbits, p_opaque_nbits),
                                        p_srcdest_nbits));
  assign w_in_payload = pl_t'(msg_field(w_in_wide, payload_lsb(), p_payload_nbits));

  assign w_out_wide = msg_pack(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits,
                               msg_wide_t'(req_dest), msg_wide_t'(c_SRC_ID),
                               msg_wide_t'(w_alloc_tag), msg_wide_t'(req_payload));

  // Handshakes: both registers behave as 1-entry pipes, so a full register
  // can still accept when its consumer drains it in the same cycle.
  assign req_rdy    = (~r_out_val | net_out_rdy) & w_alloc_ok;
  assign w_req_fire = req_val & req_rdy;
  assign net_in_rdy = ~r_resp_val | resp_rdy;
  assign w_in_fire  = net_in_val & net_in_rdy;

  // A return is retired only if its tag is in flight (and, when enabled,
  // it came back from the port it was sent to); otherwise it is swallowed.
  assign w_accept = w_in_fire & w_tag_busy & w_src_ok;
  assign w_reject = w_in_fire & ~(w_tag_busy & w_src_ok);

  net_endpoint_tag_alloc #(
    .TAG_NBITS       (p_opaque_nbits),
    .MAX_OUTSTANDING (p_max_outstanding)
  ) u_tag_alloc (
    .clk             (clk),
    .rst             (reset),
    .i_alloc         (w_req_fire),
    .o_alloc_ok      (w_alloc_ok),
    .o_alloc_tag     (w_alloc_tag),
    .i_free          (w_accept),
    .i_free_tag      (w_in_tag),
    .o_free_tag_busy (w_tag_busy),
    .o_count         (outstanding)
  );

`ifdef NET_ENDPOINT_SRC_CHECK_EN
  localparam int NUM_TAGS = 2 ** p_opaque_nbits;

  sd_t r_dest_tbl [NUM_TAGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_dest_tbl[i] <= '0;
      end
    end else if (w_req_fire) begin
      r_dest_tbl[w_alloc_tag] <= req_dest;
    end
  end

  assign w_src_ok = (r_dest_tbl[w_in_tag] == w_in_src);
`else
  assign w_src_ok = 1'b1;
`endif

  // Output register: holds the message stable while the network stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_val <= 1'b0;
      r_out_msg <= '0;
    end else if (w_req_fire) begin
      r_out_val <= 1'b1;
      r_out_msg <= msg_t'(w_out_wide);
    end else if (net_out_rdy) begin
      r_out_val <= 1'b0;
    end
  end

  // Response register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_val     <= 1'b0;
      r_resp_src     <= '0;
      r_resp_payload <= '0;
    end else if (w_accept) begin
      r_resp_val     <= 1'b1;
      r_resp_src     <= w_in_src;
      r_resp_payload <= w_in_payload;
    end else if (resp_rdy) begin
      r_resp_val <= 1'b0;
    end
  end

  // Sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_tag <= 1'b0;
    end else if (w_reject) begin
      r_err_tag <= 1'b1;
    end
  end

  assign net_out_val  = r_out_val;
  assign net_out_msg  = r_out_msg;
  assign resp_val     = r_resp_val;
  assign resp_src     = r_resp_src;
  assign resp_payload = r_resp_payload;
  assign err_tag      = r_err_tag;

endmodule

`default_nettype wire

// File: tb/tb_net_endpoint_adapter.sv
// ============================================================================
// Module      : tb_net_endpoint_adapter
// Description : Self-checking bench for net_endpoint_adapter. Directed steps
//               followed by randomized traffic with a loopback network that
//               returns injected messages in random order. Expectations come
//               from a tag-set reference model kept in the bench.
//               Honours NET_ENDPOINT_SRC_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_endpoint_adapter;

  localparam int P    = 32;
  localparam int O    = 3;
  localparam int S    = 3;
  localparam int SRC  = 1;
  localparam int MAXO = 4;
  localparam int MW   = P + O + 2 * S;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [S-1:0]  req_dest;
  logic [P-1:0]  req_payload;
  logic          net_out_val;
  logic          net_out_rdy;
  logic [MW-1:0] net_out_msg;
  logic          net_in_val;
  logic          net_in_rdy;
  logic [MW-1:0] net_in_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [S-1:0]  resp_src;
  logic [P-1:0]  resp_payload;
  logic          err_tag;
  logic [O:0]    outstanding;

  net_endpoint_adapter #(
    .p_payload_nbits   (P),
    .p_opaque_nbits    (O),
    .p_srcdest_nbits   (S),
    .p_src_id          (SRC),
    .p_max_outstanding (MAXO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .net_out_val  (net_out_val),
    .net_out_rdy  (net_out_rdy),
    .net_out_msg  (net_out_msg),
    .net_in_val   (net_in_val),
    .net_in_rdy   (net_in_rdy),
    .net_in_msg   (net_in_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_src     (resp_src),
    .resp_payload (resp_payload),
    .err_tag      (err_tag),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  // Reference model: set of in-flight tags plus the two 1-entry pipes.
  bit            m_busy [8];
  int            m_dest [8];
  bit            m_err;
  bit            m_oval;
  logic [MW-1:0] m_omsg;
  bit            m_rval;
  int            m_rsrc;
  logic [P-1:0]  m_rpay;

  logic [MW-1:0] ret_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [S-1:0] d, input logic [S-1:0] s,
                                       input logic [O-1:0] t, input logic [P-1:0] p);
    return {d, s, t, p};
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < MAXO; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic idle();
    req_val     = 1'b0;
    req_dest    = '0;
    req_payload = '0;
    net_out_rdy = 1'b1;
    net_in_val  = 1'b0;
    net_in_msg  = '0;
    resp_rdy    = 1'b1;
  endtask

  // Called at a negative edge with inputs already applied.
  task automatic cycle(input string ph);
    bit e_req_rdy, e_in_rdy, rfire, ifire, ok;
    int a, t, isrc;
    #1;
    a         = m_lowest_free();
    e_req_rdy = (!m_oval || net_out_rdy) && (m_count() < MAXO) && (a >= 0);
    e_in_rdy  = !m_rval || resp_rdy;
    chk({ph, "_req_rdy"}, 64'(req_rdy), 64'(e_req_rdy));
    chk({ph, "_net_in_rdy"}, 64'(net_in_rdy), 64'(e_in_rdy));
    rfire = req_val && e_req_rdy;
    ifire = net_in_val && e_in_rdy;
    if (net_out_val && net_out_rdy) ret_q.push_back(net_out_msg);
    ok = 1'b0;
    t  = 0;
    isrc = 0;
    if (ifire) begin
      t    = int'(net_in_msg[P+O-1:P]);
      isrc = int'(net_in_msg[P+O+S-1:P+O]);
      ok   = m_busy[t];
`ifdef NET_ENDPOINT_SRC_CHECK_EN
      if (m_dest[t] != isrc) ok = 1'b0;
`endif
      if (!ok) m_err = 1'b1;
    end
    if (rfire) begin
      m_oval    = 1'b1;
      m_omsg    = mk(req_dest, S'(SRC), O'(a), req_payload);
      m_busy[a] = 1'b1;
      m_dest[a] = int'(req_dest);
    end else if (net_out_rdy) begin
      m_oval = 1'b0;
    end
    if (ok) begin
      m_busy[t] = 1'b0;
      m_rval    = 1'b1;
      m_rsrc    = isrc;
      m_rpay    = net_in_msg[P-1:0];
    end else if (resp_rdy) begin
      m_rval = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({ph, "_net_out_val"}, 64'(net_out_val), 64'(m_oval));
    if (m_oval) chk({ph, "_net_out_msg"}, 64'(net_out_msg), 64'(m_omsg));
    chk({ph, "_resp_val"}, 64'(resp_val), 64'(m_rval));
    if (m_rval) begin
      chk({ph, "_resp_src"}, 64'(resp_src), 64'(m_rsrc));
      chk({ph, "_resp_payload"}, 64'(resp_payload), 64'(m_rpay));
    end
    chk({ph, "_err_tag"}, 64'(err_tag), 64'(m_err));
    chk({ph, "_outstanding"}, 64'(outstanding), 64'(m_count()));
    @(negedge clk);
  endtask

  // Called at a negative edge; leaves the bench at the next negative edge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 1'b0;
      m_dest[i] = 0;
    end
    m_err  = 1'b0;
    m_oval = 1'b0;
    m_rval = 1'b0;
    @(negedge clk);
    chk("rst_net_out_val", 64'(net_out_val), 64'(0));
    chk("rst_net_out_msg", 64'(net_out_msg), 64'(0));
    chk("rst_resp_val", 64'(resp_val), 64'(0));
    chk("rst_resp_payload", 64'(resp_payload), 64'(0));
    chk("rst_err_tag", 64'(err_tag), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_req_rdy", 64'(req_rdy), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] m;
    logic [MW-1:0] r;
    int            pick;
    bit            corrupt;

    idle();
    reset = 1'b0;
    do_reset();

    // 1: single request
    req_val = 1'b1; req_dest = 3'd2; req_payload = 32'hA5;
    cycle("t1");
    chk("t1_msg", 64'(net_out_msg), 64'(mk(3'd2, S'(SRC), 3'd0, 32'hA5)));
    chk("t1_outstanding", 64'(outstanding), 64'(1));
    idle();
    cycle("t1_idle");

    // 2: fill all tags
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_val = 1'b1; req_dest = S'(i); req_payload = $urandom;
      cycle("t2_req");
      chk("t2_tag", 64'(net_out_msg[P+O-1:P]), 64'(i));
    end
    cycle("t2_full");
    chk("t2_req_rdy_low", 64'(req_rdy), 64'(0));
    chk("t2_outstanding", 64'(outstanding), 64'(4));

    // 3: same-cycle free and alloc
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_val = 1'b1; req_dest = S'(5 + i); req_payload = 32'h1000_0000 + P'(i);
      cycle("t3_fill");
    end
    req_val = 1'b1; req_dest = 3'd3; req_payload = 32'h3333;
    net_in_val = 1'b1; net_in_msg = mk(S'(SRC), 3'd7, 3'd2, 32'hCAFE_0002);
    cycle("t3_same");
    chk("t3_no_reuse", 64'(net_out_msg[P+O-1:P]), 64'(3));
    chk("t3_resp_payload", 64'(resp_payload), 64'(32'hCAFE_0002));
    net_in_val = 1'b0; req_dest = 3'd4; req_payload = 32'h4444;
    cycle("t3_next");
    chk("t3_reuse", 64'(net_out_msg[P+O-1:P]), 64'(2));

    // 4: unknown tag
    idle();
    net_in_val = 1'b1; net_in_msg = mk(S'(SRC), 3'd0, 3'd5, 32'hDEAD);
    cycle("t4_bad");
    idle();
    chk("t4_err", 64'(err_tag), 64'(1));
    chk("t4_resp_val", 64'(resp_val), 64'(0));
    repeat (3) cycle("t4_idle");
    chk("t4_err_sticky", 64'(err_tag), 64'(1));

    // 5: response backpressure
    resp_rdy = 1'b0;
    net_in_val = 1'b1; net_in_msg = mk(S'(SRC), 3'd5, 3'd0, 32'hAAAA_0000);
    cycle("t5_load");
    net_in_msg = mk(S'(SRC), 3'd6, 3'd1, 32'hBBBB_0001);
    repeat (3) cycle("t5_hold");
    chk("t5_in_rdy_low", 64'(net_in_rdy), 64'(0));
    chk("t5_src_stable", 64'(resp_src), 64'(5));
    chk("t5_pay_stable", 64'(resp_payload), 64'(32'hAAAA_0000));
    resp_rdy = 1'b1;
    cycle("t5_drain1");
    chk("t5_drain1_pay", 64'(resp_payload), 64'(32'hBBBB_0001));
    net_in_msg = mk(S'(SRC), 3'd4, 3'd2, 32'hCCCC_0002);
    cycle("t5_drain2");
    chk("t5_drain2_pay", 64'(resp_payload), 64'(32'hCCCC_0002));
    idle();
    cycle("t5_empty");
    chk("t5_resp_val_low", 64'(resp_val), 64'(0));

    // 6: wrong-source return
    do_reset();
    req_val = 1'b1; req_dest = 3'd1; req_payload = 32'h6666;
    cycle("t6_req");
    idle();
    net_in_val = 1'b1; net_in_msg = mk(S'(SRC), 3'd3, 3'd0, 32'h6666);
    cycle("t6_ret");
    idle();
    cycle("t6_idle");
`ifdef NET_ENDPOINT_SRC_CHECK_EN
    chk("t6_err", 64'(err_tag), 64'(1));
    chk("t6_outstanding", 64'(outstanding), 64'(1));
`else
    chk("t6_err", 64'(err_tag), 64'(0));
    chk("t6_outstanding", 64'(outstanding), 64'(0));
`endif

    // Randomized traffic through a loopback network
    do_reset();
    ret_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (c == 2200) do_reset();
      req_val     = ($urandom % 3) != 0;
      req_dest    = S'($urandom);
      req_payload = $urandom;
      net_out_rdy = ($urandom % 4) != 0;
      resp_rdy    = ($urandom % 4) != 0;
      net_in_val  = 1'b0;
      net_in_msg  = '0;
      pick        = -1;
      corrupt     = 1'b0;
      if (ret_q.size() > 0 && ($urandom % 2) == 1) begin
        pick = int'($urandom_range(0, ret_q.size() - 1));
        m    = ret_q[pick];
        r    = mk(S'(SRC), m[MW-1:MW-S], m[P+O-1:P], m[P-1:0]);
        if ($urandom % 50 == 0) begin
          corrupt = 1'b1;
          r[P+O] = ~r[P+O];
        end
        net_in_val = 1'b1;
        net_in_msg = r;
      end else if ($urandom % 100 == 0) begin
        net_in_val = 1'b1;
        net_in_msg = mk(S'(SRC), S'($urandom), O'(4 + ($urandom % 4)), $urandom);
      end
      if (pick >= 0 && !corrupt && (!m_rval || resp_rdy)) ret_q.delete(pick);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
